pc_stack_seq: RTL and testbench

//  Serialises the 16-bit PC onto the stack as two byte writes (CALL/RST/interrupt entry) and

---
 rtl/pc_stack_seq_pkg.sv | 36 +++
 rtl/pc_stack_seq_if.sv | 32 +++
 rtl/pc_stack_seq.sv | 129 ++++++++++++
 tb/tb_pc_stack_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_stack_seq_pkg.sv
// Shared types and constants for the PC stack sequencer: state encoding,
// stack pointer reset value and the registered memory request payload.
package pc_stack_seq_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  localparam logic [ADDR_W-1:0] SP_RESET_DEFAULT = 16'hFFFE;
  localparam logic [ADDR_W-1:0] SP_DEC           = '1;
  localparam logic [ADDR_W-1:0] SP_INC           = ADDR_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PUSH_HI = 3'd1,
    ST_PUSH_LO = 3'd2,
    ST_POP_LO  = 3'd3,
    ST_POP_HI  = 3'd4,
    ST_FIN     = 3'd5
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              wr;
    logic              rd;
  } mem_req_t;

  function automatic logic is_push_state(input state_t s);
    return (s == ST_PUSH_HI) || (s == ST_PUSH_LO);
  endfunction

  function automatic logic is_pop_state(input state_t s);
    return (s == ST_POP_LO) || (s == ST_POP_HI);
  endfunction

endpackage

// File: rtl/pc_stack_seq_if.sv
// Control, memory-bus and PC-return signals of the PC stack sequencer.
interface pc_stack_seq_if;
  import pc_stack_seq_pkg::*;

  logic              start_push;
  logic              start_pop;
  logic [ADDR_W-1:0] pc_in;
  logic              sp_load;
  logic [ADDR_W-1:0] sp_load_val;
  logic [DATA_W-1:0] data_in;
  logic              mem_ready;
  logic [ADDR_W-1:0] addr_out;
  logic [DATA_W-1:0] data_out;
  logic              mem_wr;
  logic              mem_rd;
  logic [ADDR_W-1:0] sp;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] pc_out;
  logic              pc_out_valid;

  modport master (
    output start_push, start_pop, pc_in, sp_load, sp_load_val, data_in, mem_ready,
    input  addr_out, data_out, mem_wr, mem_rd, sp, busy, done, pc_out, pc_out_valid
  );

  modport slave (
    input  start_push, start_pop, pc_in, sp_load, sp_load_val, data_in, mem_ready,
    output addr_out, data_out, mem_wr, mem_rd, sp, busy, done, pc_out, pc_out_valid
  );

endinterface

// File: rtl/pc_stack_seq.sv
// Pushes the PC onto the stack as two byte writes and pops a return address
// from two byte reads; owns the stack pointer.
module pc_stack_seq
  import pc_stack_seq_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SP_RESET = SP_RESET_DEFAULT
) (
  input logic           clock,
  input logic           reset,
  pc_stack_seq_if.slave bus
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] sp, sp_nxt, sp_delta;
  logic              sp_ld;
  logic [ADDR_W-1:0] pc_lat, pc_lat_nxt;
  logic [ADDR_W-1:0] pc_out, pc_out_nxt;
  logic [DATA_W-1:0] lo, lo_nxt;
  logic              op_pop, op_pop_nxt;
  mem_req_t          req, req_nxt;
  logic              busy, busy_nxt;
  logic              done, done_nxt;
  logic              pc_out_valid, valid_nxt;

  // State and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      sp           <= SP_RESET;
      pc_lat       <= '0;
      pc_out       <= '0;
      lo           <= '0;
      op_pop       <= 1'b0;
      req          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pc_out_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      sp           <= sp_nxt;
      pc_lat       <= pc_lat_nxt;
      pc_out       <= pc_out_nxt;
      lo           <= lo_nxt;
      op_pop       <= op_pop_nxt;
      req          <= req_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      pc_out_valid <= valid_nxt;
    end
  end

  // Next-state: push has priority over pop; memory stalls hold the state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.start_push)     state_nxt = ST_PUSH_HI;
        else if (bus.start_pop) state_nxt = ST_POP_LO;
      end
      ST_PUSH_HI: if (bus.mem_ready) state_nxt = ST_PUSH_LO;
      ST_PUSH_LO: if (bus.mem_ready) state_nxt = ST_FIN;
      ST_POP_LO:  if (bus.mem_ready) state_nxt = ST_POP_HI;
      ST_POP_HI:  if (bus.mem_ready) state_nxt = ST_FIN;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and output next values; sp shares one adder for +1/-1
  always_comb begin
    sp_delta   = '0;
    sp_ld      = 1'b0;
    pc_lat_nxt = pc_lat;
    pc_out_nxt = pc_out;
    lo_nxt     = lo;
    op_pop_nxt = op_pop;
    case (state)
      ST_IDLE: begin
        if (bus.start_push) begin
          pc_lat_nxt = bus.pc_in;
          sp_delta   = SP_DEC;
          op_pop_nxt = 1'b0;
        end else if (bus.start_pop) begin
          op_pop_nxt = 1'b1;
        end else if (bus.sp_load) begin
          sp_ld = 1'b1;
        end
      end
      ST_PUSH_HI: if (bus.mem_ready) sp_delta = SP_DEC;
      ST_POP_LO: begin
        if (bus.mem_ready) begin
          lo_nxt   = bus.data_in;
          sp_delta = SP_INC;
        end
      end
      ST_POP_HI: begin
        if (bus.mem_ready) begin
          pc_out_nxt = {bus.data_in, lo};
          sp_delta   = SP_INC;
        end
      end
      default: ;
    endcase

    sp_nxt = sp_ld ? bus.sp_load_val : sp + sp_delta;

    // Request tracks the upcoming state so it is visible for the whole bus state
    req_nxt    = req;
    req_nxt.wr = is_push_state(state_nxt);
    req_nxt.rd = is_pop_state(state_nxt);
    if (is_push_state(state_nxt) || is_pop_state(state_nxt)) req_nxt.addr = sp_nxt;
    if (state_nxt == ST_PUSH_HI)      req_nxt.data = pc_lat_nxt[ADDR_W-1:DATA_W];
    else if (state_nxt == ST_PUSH_LO) req_nxt.data = pc_lat_nxt[DATA_W-1:0];

    busy_nxt  = (state_nxt != ST_IDLE);
    done_nxt  = (state == ST_FIN);
    valid_nxt = (state == ST_FIN) && op_pop;
  end

  assign bus.addr_out     = req.addr;
  assign bus.data_out     = req.data;
  assign bus.mem_wr       = req.wr;
  assign bus.mem_rd       = req.rd;
  assign bus.sp           = sp;
  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.pc_out       = pc_out;
  assign bus.pc_out_valid = pc_out_valid;

endmodule

// File: tb/tb_pc_stack_seq.sv
// Directed bench for pc_stack_seq with a byte memory model and write/read logs.
module tb_pc_stack_seq;

  logic clock;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   cyc;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  logic [7:0]  mem [0:65535];
  wr_t         wlog[$];
  logic [15:0] rlog[$];

  pc_stack_seq_if bus();

  pc_stack_seq dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign bus.data_in = mem[bus.addr_out];

  always @(posedge clock) begin
    if (bus.mem_wr && bus.mem_ready) begin
      mem[bus.addr_out] = bus.data_out;
      wlog.push_back({bus.addr_out, bus.data_out});
    end
    if (bus.mem_rd && bus.mem_ready) rlog.push_back(bus.addr_out);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_sp(input logic [15:0] v);
    bus.sp_load     = 1'b1;
    bus.sp_load_val = v;
    tick();
    bus.sp_load     = 1'b0;
  endtask

  task automatic start_op(input bit push, input logic [15:0] pc);
    if (push) begin
      bus.start_push = 1'b1;
      bus.pc_in      = pc;
    end else begin
      bus.start_pop = 1'b1;
    end
    tick();
    bus.start_push = 1'b0;
    bus.start_pop  = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [15:0] a, input logic [7:0] d);
    logic [31:0] got;
    got = 32'hFFFF_FFFF;
    if (idx < wlog.size()) got = 32'(wlog[idx]);
    check(tag, got, 32'({a, d}));
  endtask

  task automatic check_rd(input string tag, input int idx, input logic [15:0] a);
    logic [31:0] got;
    got = 32'hFFFF_FFFF;
    if (idx < rlog.size()) got = 32'(rlog[idx]);
    check(tag, got, 32'(a));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bus.start_push  = 1'b0;
    bus.start_pop   = 1'b0;
    bus.pc_in       = '0;
    bus.sp_load     = 1'b0;
    bus.sp_load_val = '0;
    bus.mem_ready   = 1'b1;
    reset           = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_sp",    32'(bus.sp), 'hFFFE);
    check("rst_busy",  32'(bus.busy), 0);
    check("rst_done",  32'(bus.done), 0);
    check("rst_wr",    32'(bus.mem_wr), 0);
    check("rst_rd",    32'(bus.mem_rd), 0);
    check("rst_addr",  32'(bus.addr_out), 0);
    check("rst_data",  32'(bus.data_out), 0);
    check("rst_pc",    32'(bus.pc_out), 0);
    check("rst_valid", 32'(bus.pc_out_valid), 0);
    reset = 1'b0;
    tick();

    // 1: push 0x1234 from sp 0xD000, cycle by cycle
    load_sp(16'hD000);
    check("t1_sp_load", 32'(bus.sp), 'hD000);
    wlog.delete();
    start_op(1'b1, 16'h1234);
    check("t1_hi_wr",   32'(bus.mem_wr), 1);
    check("t1_hi_addr", 32'(bus.addr_out), 'hCFFF);
    check("t1_hi_data", 32'(bus.data_out), 'h12);
    check("t1_hi_busy", 32'(bus.busy), 1);
    tick();
    check("t1_lo_addr", 32'(bus.addr_out), 'hCFFE);
    check("t1_lo_data", 32'(bus.data_out), 'h34);
    check("t1_lo_sp",   32'(bus.sp), 'hCFFE);
    tick();
    check("t1_fin_wr",   32'(bus.mem_wr), 0);
    check("t1_fin_done", 32'(bus.done), 0);
    tick();
    check("t1_done",    32'(bus.done), 1);
    check("t1_novalid", 32'(bus.pc_out_valid), 0);
    tick();
    check("t1_done_pulse", 32'(bus.done), 0);
    check("t1_wcount", 32'(wlog.size()), 2);
    check_wr("t1_w0", 0, 16'hCFFF, 8'h12);
    check_wr("t1_w1", 1, 16'hCFFE, 8'h34);
    check("t1_sp", 32'(bus.sp), 'hCFFE);

    // 2: pop back 0x1234
    rlog.delete();
    start_op(1'b0, 16'h0000);
    check("t2_rd",   32'(bus.mem_rd), 1);
    check("t2_addr", 32'(bus.addr_out), 'hCFFE);
    wait_done(cyc);
    check("t2_latency", 32'(cyc), 3);
    check("t2_pc",      32'(bus.pc_out), 'h1234);
    check("t2_valid",   32'(bus.pc_out_valid), 1);
    check("t2_sp",      32'(bus.sp), 'hD000);
    check("t2_rcount",  32'(rlog.size()), 2);
    check_rd("t2_r0", 0, 16'hCFFE);
    check_rd("t2_r1", 1, 16'hCFFF);
    tick();
    check("t2_valid_pulse", 32'(bus.pc_out_valid), 0);
    check("t2_pc_hold",     32'(bus.pc_out), 'h1234);

    // 3: wrap-around on push and pop
    load_sp(16'h0000);
    wlog.delete();
    start_op(1'b1, 16'hABCD);
    wait_done(cyc);
    check("t3_push_latency", 32'(cyc), 3);
    check_wr("t3_w0", 0, 16'hFFFF, 8'hAB);
    check_wr("t3_w1", 1, 16'hFFFE, 8'hCD);
    check("t3_push_sp", 32'(bus.sp), 'hFFFE);
    mem[16'hFFFF] = 8'h78;
    mem[16'h0000] = 8'h56;
    load_sp(16'hFFFF);
    rlog.delete();
    start_op(1'b0, 16'h0000);
    wait_done(cyc);
    check("t3_pop_pc", 32'(bus.pc_out), 'h5678);
    check("t3_pop_sp", 32'(bus.sp), 'h0001);
    check_rd("t3_r0", 0, 16'hFFFF);
    check_rd("t3_r1", 1, 16'h0000);

    // 4: four stall cycles in PUSH_HI
    load_sp(16'h2000);
    wlog.delete();
    bus.mem_ready = 1'b0;
    start_op(1'b1, 16'h5A5A);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_stall_wr",   32'(bus.mem_wr), 1);
      check("t4_stall_addr", 32'(bus.addr_out), 'h1FFF);
      check("t4_stall_data", 32'(bus.data_out), 'h5A);
      check("t4_stall_sp",   32'(bus.sp), 'h1FFF);
    end
    bus.mem_ready = 1'b1;
    wait_done(cyc);
    check("t4_latency", 32'(cyc), 3);
    check("t4_sp",      32'(bus.sp), 'h1FFE);
    check("t4_wcount",  32'(wlog.size()), 2);

    // 5: push wins over pop; starts and sp_load while busy are ignored
    load_sp(16'h3000);
    wlog.delete();
    bus.start_push = 1'b1;
    bus.start_pop  = 1'b1;
    bus.pc_in      = 16'h1111;
    tick();
    check("t5_wr",   32'(bus.mem_wr), 1);
    check("t5_rd",   32'(bus.mem_rd), 0);
    check("t5_addr", 32'(bus.addr_out), 'h2FFF);
    bus.pc_in       = 16'h2222;
    bus.sp_load     = 1'b1;
    bus.sp_load_val = 16'h9999;
    repeat (3) tick();
    bus.start_push = 1'b0;
    bus.start_pop  = 1'b0;
    bus.sp_load    = 1'b0;
    check("t5_done",    32'(bus.done), 1);
    check("t5_novalid", 32'(bus.pc_out_valid), 0);
    check("t5_sp",      32'(bus.sp), 'h2FFE);
    check("t5_wcount",  32'(wlog.size()), 2);
    check_wr("t5_w1", 1, 16'h2FFE, 8'h11);
    tick();
    check("t5_idle_busy", 32'(bus.busy), 0);
    check("t5_idle_wr",   32'(bus.mem_wr), 0);

    // 6: reset during PUSH_LO
    load_sp(16'h4000);
    wlog.delete();
    start_op(1'b1, 16'hBEEF);
    tick();
    check("t6_lo_wr", 32'(bus.mem_wr), 1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_wr",   32'(bus.mem_wr), 0);
    check("t6_rst_sp",   32'(bus.sp), 'hFFFE);
    check("t6_rst_busy", 32'(bus.busy), 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_no_done", 32'(bus.done), 0);
    end
    check("t6_wcount", 32'(wlog.size()), 1);
    check_wr("t6_w0", 0, 16'h3FFF, 8'hBE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
